// File: rtl/interleaver_seq_gen.sv
// interleaver_seq_gen
//   Produces, one cycle per step, the set of z memory row indices (one per
//   bank/lane) that an interleaved fan-out sweep reads. A block is fo sweeps
//   of p/z cycles each. Within a sweep every lane starts at its own offset
//   (sweepstart) and walks its bank's p/z rows cyclically, so each row of a
//   bank is visited exactly once per sweep.
//
// Ports
//   clk                  clock, all state changes on posedge
//   reset                synchronous, active-high
//   start                begin a block (only honoured in IDLE or on the last cycle)
//   cont                 on the last cycle, restart the block automatically
//   stall                hold every register for this cycle (RUN only)
//   memory_index_package lane k at bits [k*IW +: IW], registered
//   cycle_index          current cycle within the block, registered
//   sweep_index          cycle_index / (p/z), registered
//   valid                package holds a live index set
//   last                 valid and cycle_index == cpc-1
//   done                 one-cycle pulse after the last cycle is accepted
module interleaver_seq_gen #(
  parameter int unsigned fo = 2,
  parameter int unsigned p  = 32,
  parameter int unsigned z  = 8,
  parameter logic [$clog2(p/z)-1:0] sweepstart [0:fo*z-1] = '{
    2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3,
    2'd2, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2}
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  cont,
  input  logic                                  stall,
  output logic [$clog2(p)*z-1:0]                memory_index_package,
  output logic [$clog2(fo*p/z)-1:0]             cycle_index,
  output logic [((fo > 1) ? $clog2(fo) : 1)-1:0] sweep_index,
  output logic                                  valid,
  output logic                                  last,
  output logic                                  done
);

  localparam int unsigned RPB = p / z;                  // rows per bank
  localparam int unsigned OW  = $clog2(RPB);
  localparam int unsigned CPC = fo * RPB;               // cycles per block
  localparam int unsigned CW  = $clog2(CPC);
  localparam int unsigned IW  = $clog2(p);
  localparam int unsigned SW  = (fo > 1) ? $clog2(fo) : 1;
  localparam int unsigned XW  = (fo * z > 1) ? $clog2(fo * z) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   nxt_c;
  int unsigned     s_n;
  logic [OW-1:0]   o_n;
  logic [OW-1:0]   off;
  logic [XW-1:0]   sel;
  logic [IW*z-1:0] pkg_n;
  logic [SW-1:0]   sweep_n;
  logic            last_n;

  // Everything the next loaded cycle needs is derived from the registered
  // state only, so outputs never see a combinational input path. The next
  // cycle is 0 when entering from IDLE or wrapping after the last cycle.
  always_comb begin
    nxt_c = (state == RUN && !last) ? cycle_index + CW'(1) : '0;
    s_n   = 32'(nxt_c) / RPB;
    o_n   = OW'(32'(nxt_c) % RPB);
    pkg_n = '0;
    off   = '0;
    sel   = '0;
    for (int unsigned k = 0; k < z; k++) begin
      sel = XW'(s_n * z + k);
      off = sweepstart[sel] + o_n;   // wraps within the bank
      pkg_n[k*IW +: IW] = IW'(k * RPB) + IW'(off);
    end
    sweep_n = SW'(s_n);
    last_n  = (nxt_c == CW'(CPC - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      valid                <= 1'b0;
      last                 <= 1'b0;
      done                 <= 1'b0;
      cycle_index          <= '0;
      sweep_index          <= '0;
      memory_index_package <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state                <= RUN;
            valid                <= 1'b1;
            cycle_index          <= nxt_c;
            sweep_index          <= sweep_n;
            memory_index_package <= pkg_n;
            last                 <= last_n;
          end else begin
            valid <= 1'b0;
            last  <= 1'b0;
          end
        end
        RUN: begin
          if (stall) begin
            done <= 1'b0;
          end else if (last) begin
            done <= 1'b1;
            if (start || cont) begin
              // back-to-back restart: nxt_c is already 0 here
              valid                <= 1'b1;
              cycle_index          <= nxt_c;
              sweep_index          <= sweep_n;
              memory_index_package <= pkg_n;
              last                 <= last_n;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              last  <= 1'b0;
            end
          end else begin
            done                 <= 1'b0;
            cycle_index          <= nxt_c;
            sweep_index          <= sweep_n;
            memory_index_package <= pkg_n;
            last                 <= last_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_seq_gen.sv
// Bench for interleaver_seq_gen at default parameters (fo=2, p=32, z=8).
module tb_interleaver_seq_gen;

  localparam int SS [16] = '{1,3,2,0,0,2,1,3,2,0,3,1,3,1,0,2};

  logic        clk = 1'b0;
  logic        reset, start, cont, stall;
  logic [39:0] memory_index_package;
  logic [2:0]  cycle_index;
  logic [0:0]  sweep_index;
  logic        valid, last, done;

  interleaver_seq_gen dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .cont                 (cont),
    .stall                (stall),
    .memory_index_package (memory_index_package),
    .cycle_index          (cycle_index),
    .sweep_index          (sweep_index),
    .valid                (valid),
    .last                 (last),
    .done                 (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Index rule straight from the definition: lane k of cycle c reads
  // row k*4 + ((start offset + position in sweep) mod 4).
  function automatic logic [39:0] ref_pkg(input int c);
    logic [39:0] r;
    int s, o;
    s = c / 4;
    o = c % 4;
    r = '0;
    for (int k = 0; k < 8; k++)
      r[k*5 +: 5] = 5'(k * 4 + (SS[s*8 + k] + o) % 4);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, st, ct, sl;
    logic ev, el, ed;
    int   ec;
    int   el0;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, st, ct, sl, ev, el, ed, input int ec, el0);
    vec_t v;
    v.rst = rst; v.st = st; v.ct = ct; v.sl = sl;
    v.ev = ev; v.el = el; v.ed = ed; v.ec = ec; v.el0 = el0;
    tbl.push_back(v);
  endtask

  // reference model state
  bit m_act, m_done, m_zero;
  int m_c;
  logic [31:0] seen [8];

  initial begin
    logic [4:0]  exp0 [8];
    logic [39:0] p0;
    logic [12:0] a, e;

    reset = 1'b1; start = 1'b0; cont = 1'b0; stall = 1'b0;

    //  rst st ct sl | v l d  c  lane0
    add(1,0,0,0, 0,0,0, 0,0);   // reset state
    add(0,1,0,0, 1,0,0, 0,1);   // single block
    add(0,0,0,0, 1,0,0, 1,2);
    add(0,0,0,0, 1,0,0, 2,3);
    add(0,0,0,0, 1,0,0, 3,0);
    add(0,0,0,0, 1,0,0, 4,2);
    add(0,0,0,0, 1,0,0, 5,3);
    add(0,0,0,0, 1,0,0, 6,0);
    add(0,0,0,0, 1,1,0, 7,1);
    add(0,0,0,0, 0,0,1, 7,1);   // done, outputs held
    add(0,0,0,1, 0,0,0, 7,1);   // stall in IDLE harmless
    add(0,1,0,0, 1,0,0, 0,1);   // stall block
    add(0,0,0,0, 1,0,0, 1,2);
    add(0,0,0,0, 1,0,0, 2,3);
    add(0,0,0,1, 1,0,0, 2,3);
    add(0,1,0,1, 1,0,0, 2,3);
    add(0,0,0,1, 1,0,0, 2,3);
    add(0,0,0,0, 1,0,0, 3,0);
    add(0,0,0,0, 1,0,0, 4,2);
    add(0,0,0,0, 1,0,0, 5,3);
    add(0,0,0,0, 1,0,0, 6,0);
    add(0,0,0,0, 1,1,0, 7,1);
    add(0,0,1,0, 1,0,1, 0,1);   // cont restart, no bubble
    add(0,0,0,0, 1,0,0, 1,2);
    add(0,0,0,0, 1,0,0, 2,3);
    add(0,1,0,0, 1,0,0, 3,0);   // mid-block start ignored
    add(0,0,0,0, 1,0,0, 4,2);
    add(0,0,0,0, 1,0,0, 5,3);
    add(0,0,0,0, 1,0,0, 6,0);
    add(0,0,0,0, 1,1,0, 7,1);
    add(0,1,0,0, 1,0,1, 0,1);   // start with last: back-to-back
    add(0,0,0,0, 1,0,0, 1,2);
    add(0,0,0,0, 1,0,0, 2,3);
    add(0,0,0,0, 1,0,0, 3,0);
    add(0,0,0,0, 1,0,0, 4,2);
    add(0,0,0,0, 1,0,0, 5,3);
    add(1,1,1,0, 0,0,0, 0,0);   // reset wins over start/cont
    add(0,0,0,0, 0,0,0, 0,0);   // abandoned block does not resume
    add(0,1,0,0, 1,0,0, 0,1);   // fresh block at c=0

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; start = tbl[i].st; cont = tbl[i].ct; stall = tbl[i].sl;
      step();
      a = {valid, last, done, cycle_index, sweep_index, memory_index_package[4:0]};
      e = {tbl[i].ev, tbl[i].el, tbl[i].ed, 3'(tbl[i].ec), 1'(tbl[i].ec / 4), 5'(tbl[i].el0)};
      check($sformatf("vec%0d", i), 64'(a), 64'(e));
    end

    exp0 = '{5'd1, 5'd7, 5'd10, 5'd12, 5'd16, 5'd22, 5'd25, 5'd31};
    p0 = '0;
    for (int k = 0; k < 8; k++) p0[k*5 +: 5] = exp0[k];
    check("pkg_c0_after_reset", 64'(memory_index_package), 64'(p0));
    start = 1'b0;
    step();
    step();
    step();
    step();   // c=4
    check("lane0_c4", 64'(memory_index_package[4:0]), 64'd2);
    step();
    step();
    step();   // c=7
    check("lane0_c7", 64'(memory_index_package[4:0]), 64'd1);
    check("last_c7", 64'(last), 64'd1);

    // randomized run against the reference model
    m_act = 0; m_done = 0; m_zero = 1; m_c = 0;
    for (int k = 0; k < 8; k++) seen[k] = '0;
    for (int i = 0; i < 3000; i++) begin
      bit fresh;
      logic [39:0] ep;
      reset = (i == 0) || ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) cont = ~cont;
      stall = ($urandom_range(0, 4) == 0);
      step();

      fresh = 0;
      if (reset) begin
        m_act = 0; m_done = 0; m_zero = 1; m_c = 0;
      end else if (!m_act) begin
        m_done = 0;
        if (start) begin m_act = 1; m_c = 0; m_zero = 0; fresh = 1; end
      end else if (stall) begin
        m_done = 0;
      end else if (m_c == 7) begin
        m_done = 1;
        if (start || cont) begin m_c = 0; fresh = 1; end
        else m_act = 0;
      end else begin
        m_done = 0;
        m_c++;
        fresh = 1;
      end

      ep = m_zero ? 40'd0 : ref_pkg(m_c);
      a = {valid, last, done, cycle_index, sweep_index, 5'd0};
      e = {m_act, 1'(m_act && m_c == 7), m_done, 3'(m_c), 1'(m_c / 4), 5'd0};
      check($sformatf("rnd_ctl%0d", i), 64'(a), 64'(e));
      check($sformatf("rnd_pkg%0d", i), 64'(memory_index_package), 64'(ep));

      if (fresh) begin
        if (m_c % 4 == 0)
          for (int k = 0; k < 8; k++) seen[k] = '0;
        for (int k = 0; k < 8; k++)
          seen[k][memory_index_package[k*5 +: 5]] = 1'b1;
        if (m_c % 4 == 3)
          for (int k = 0; k < 8; k++)
            check($sformatf("sweep_cover_lane%0d", k), 64'(seen[k]), 64'(32'hF << (k * 4)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
